// File: rtl/wb_shared_arbiter.sv
// Round-robin Wishbone arbiter: N rv_core master ports onto one shared slave bus,
// with a per-grant stall timeout so a hung peripheral cannot lock up all cores.
module wb_shared_arbiter #(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [N_MASTERS-1:0]      m_cyc_i,
  input  logic [N_MASTERS-1:0]      m_stb_i,
  input  logic [N_MASTERS-1:0]      m_we_i,
  input  logic [4*N_MASTERS-1:0]    m_sel_i,
  input  logic [32*N_MASTERS-1:0]   m_adr_i,
  input  logic [32*N_MASTERS-1:0]   m_dat_i,
  output logic [N_MASTERS-1:0]      m_ack_o,
  output logic [31:0]               m_dat_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [3:0]                s_sel_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  input  logic                      s_ack_i,
  input  logic [31:0]               s_dat_i,
  output logic [N_MASTERS-1:0]      grant_o,
  output logic                      timeout_o
);

  localparam int unsigned IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [IW-1:0]        last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 sel_cyc, sel_stb, sel_we;
  logic [3:0]           sel_sel;
  logic [31:0]          sel_adr, sel_dat;
  logic                 active, stall, force_to;
  logic [N_MASTERS-1:0] req;
  logic                 found;
  logic [IW-1:0]        nxt_idx;
  int unsigned          cand;

  // grant_q is all-zero outside GRANT, so the selected master signals are too
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_sel = '0;
    sel_adr = '0;
    sel_dat = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (grant_q[k]) begin
        sel_cyc = m_cyc_i[k];
        sel_stb = m_stb_i[k];
        sel_we  = m_we_i[k];
        sel_sel = m_sel_i[4*k +: 4];
        sel_adr = m_adr_i[32*k +: 32];
        sel_dat = m_dat_i[32*k +: 32];
      end
    end
  end

  assign active   = (state_q == GRANT);
  assign stall    = active & sel_stb & ~s_ack_i;
  assign force_to = (TIMEOUT_CYCLES != 0) && stall && (cnt_q == TO_LAST);

  assign s_cyc_o   = active & sel_cyc;
  assign s_stb_o   = active & sel_stb & ~force_to;
  assign s_we_o    = active & sel_we;
  assign s_sel_o   = sel_sel;
  assign s_adr_o   = sel_adr;
  assign s_dat_o   = sel_dat;
  assign m_ack_o   = grant_q & {N_MASTERS{active & (s_ack_i | force_to)}};
  assign m_dat_o   = !active ? '0 : (force_to ? TIMEOUT_DATA : s_dat_i);
  assign grant_o   = grant_q;
  assign timeout_o = force_to;

  assign req = m_cyc_i & m_stb_i;

  // Search starts one past the last released master, so it has lowest priority
  always_comb begin
    found   = 1'b0;
    nxt_idx = '0;
    cand    = 0;
    for (int unsigned i = 1; i <= N_MASTERS; i++) begin
      cand = (32'(last_q) + i) % N_MASTERS;
      if (!found && req[IW'(cand)]) begin
        found   = 1'b1;
        nxt_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          state_d          = GRANT;
          gidx_d           = nxt_idx;
          grant_d          = '0;
          grant_d[nxt_idx] = 1'b1;
        end
      end
      default: begin
        if (s_ack_i || force_to) begin
          cnt_d = '0;
        end else if (stall) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!sel_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(N_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_shared_arbiter.sv
// Scoreboard bench for wb_shared_arbiter: directed master traffic, a registered
// slave model, and a monitor that checks every ack and every new grant in order.
module tb_wb_shared_arbiter;

  localparam logic [31:0] HANG_ADR = 32'hDEAD_0000;

  logic         clk, rst;
  logic [3:0]   m_cyc, m_stb, m_we;
  logic [15:0]  m_sel;
  logic [127:0] m_adr, m_dat;
  logic [3:0]   m_ack_o;
  logic [31:0]  m_dat_o;
  logic         s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]   s_sel_o;
  logic [31:0]  s_adr_o, s_dat_o;
  logic         s_ack;
  logic [31:0]  s_dat;
  logic [3:0]   grant_o;
  logic         timeout_o;

  wb_shared_arbiter #(
    .N_MASTERS(4),
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_DATA(32'hFFFF_FFFF)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack), .s_dat_i(s_dat),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_q[$];
  int   n_chk, n_pass;
  int   slave_lat;
  logic fixed_en;
  logic [31:0] fixed_dat;
  int   n_one, nn[4], nf0, nf2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_ack(input int m, input logic we, input logic [31:0] adr,
                            input logic [31:0] wd, input logic [31:0] rd, input logic to);
    exp_t e;
    e.m = m; e.we = we; e.adr = adr; e.wd = wd; e.rd = rd; e.to = to;
    exp_q.push_back(e);
  endtask

  // Registered slave: counts stb cycles, acks the cycle after slave_lat is reached
  task automatic slave_model();
    logic        pend;
    logic [31:0] pend_dat;
    int          sw;
    pend = 1'b0; pend_dat = '0; sw = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        s_ack = 1'b0; s_dat = '0; pend = 1'b0; sw = 0;
      end else begin
        s_ack = pend;
        s_dat = pend ? pend_dat : '0;
        pend  = 1'b0;
        #1;
        if (s_cyc_o && s_stb_o && !s_ack && s_adr_o != HANG_ADR) begin
          sw++;
          if (sw >= slave_lat) begin
            pend     = 1'b1;
            pend_dat = fixed_en ? fixed_dat : s_adr_o + 32'd1;
            sw       = 0;
          end
        end else if (!s_cyc_o) begin
          sw = 0;
        end
      end
    end
  endtask

  task automatic monitor();
    logic [3:0] prev_g;
    exp_t e;
    int   g;
    prev_g = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_g = '0;
      end else begin
        if (m_ack_o != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected ack", 32'(m_ack_o), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("ack master", 32'(m_ack_o), 32'd1 << e.m);
            chk("ack adr", s_adr_o, e.adr);
            chk("ack we", 32'(s_we_o), 32'(e.we));
            if (e.we) chk("ack wdata", s_dat_o, e.wd);
            chk("ack rdata", m_dat_o, e.rd);
            chk("ack timeout", 32'(timeout_o), 32'(e.to));
            chk("stb at ack", 32'(s_stb_o), 32'(!e.to));
          end
        end else if (timeout_o) begin
          chk("timeout without ack", 32'(timeout_o), 32'd0);
        end
        if (grant_o != prev_g && grant_o != '0) begin
          if (gnt_q.size() == 0) begin
            chk("unexpected grant", 32'(grant_o), 32'd0);
          end else begin
            g = gnt_q.pop_front();
            chk("grant order", 32'(grant_o), 32'd1 << g);
          end
        end
        prev_g = grant_o;
      end
    end
  endtask

  task automatic txn(input int k, input logic we, input logic [31:0] adr,
                     input logic [31:0] wd, output int n);
    @(posedge clk);
    #1;
    m_cyc[k] = 1'b1; m_stb[k] = 1'b1; m_we[k] = we;
    m_sel[4*k +: 4] = 4'hF; m_adr[32*k +: 32] = adr; m_dat[32*k +: 32] = wd;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (m_ack_o[k]) break;
    end
    chk("ack arrives", 32'(m_ack_o[k]), 32'd1);
    @(posedge clk);
    #1;
    m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_we[k] = 1'b0;
  endtask

  task automatic wait_grant(input int k);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grant_o[k]) break;
    end
    chk("grant reached", 32'(grant_o[k]), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    slave_lat = 2; fixed_en = 1'b0; fixed_dat = '0;
    rst = 1'b1; s_ack = 1'b0; s_dat = '0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    fork
      slave_model();
      monitor();
    join_none
    do_reset();

    @(negedge clk);
    chk("reset grant", 32'(grant_o), 32'd0);
    chk("reset s_cyc", 32'(s_cyc_o), 32'd0);
    chk("reset m_ack", 32'(m_ack_o), 32'd0);
    chk("reset timeout", 32'(timeout_o), 32'd0);

    // Single master read
    fixed_en = 1'b1; fixed_dat = 32'h1234_5678;
    gnt_q.push_back(1);
    expect_ack(1, 1'b0, 32'h3000_0010, 32'h0, 32'h1234_5678, 1'b0);
    fork
      txn(1, 1'b0, 32'h3000_0010, 32'h0, n_one);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("stb in arbitration cycle", 32'(s_stb_o), 32'd0);
        @(negedge clk);
        chk("stb one cycle after request", 32'(s_stb_o), 32'd1);
        chk("grant m1", 32'(grant_o), 32'b0010);
      end
    join
    chk("single latency", 32'(n_one), 32'd4);
    repeat (2) @(negedge clk);
    chk("grant released", 32'(grant_o), 32'd0);
    fixed_en = 1'b0;

    // Simultaneous requests right after reset, two rounds
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        gnt_q.push_back(k);
        expect_ack(k, 1'b0, 32'h3000_0000 + 32'(k) * 32'h100, 32'h0,
                   32'h3000_0001 + 32'(k) * 32'h100, 1'b0);
      end
      fork
        txn(0, 1'b0, 32'h3000_0000, 32'h0, nn[0]);
        txn(1, 1'b0, 32'h3000_0100, 32'h0, nn[1]);
        txn(2, 1'b0, 32'h3000_0200, 32'h0, nn[2]);
        txn(3, 1'b0, 32'h3000_0300, 32'h0, nn[3]);
      join
    end

    // Fairness: m0 and m2 re-request continuously
    for (int i = 0; i < 3; i++) begin
      gnt_q.push_back(0);
      expect_ack(0, 1'b0, 32'h4000_0000 + 32'(i) * 4, 32'h0, 32'h4000_0001 + 32'(i) * 4, 1'b0);
      gnt_q.push_back(2);
      expect_ack(2, 1'b1, 32'h4200_0000 + 32'(i) * 4, 32'hA5A5_0000 + 32'(i),
                 32'h4200_0001 + 32'(i) * 4, 1'b0);
    end
    fork
      for (int i = 0; i < 3; i++) txn(0, 1'b0, 32'h4000_0000 + 32'(i) * 4, 32'h0, nf0);
      for (int i = 0; i < 3; i++) txn(2, 1'b1, 32'h4200_0000 + 32'(i) * 4, 32'hA5A5_0000 + 32'(i), nf2);
    join

    // Timeout on a hung write from m3; m1 waits and is served afterwards
    gnt_q.push_back(3);
    gnt_q.push_back(1);
    expect_ack(3, 1'b1, HANG_ADR, 32'hCAFE_0003, 32'hFFFF_FFFF, 1'b1);
    expect_ack(1, 1'b0, 32'h3000_0020, 32'h0, 32'h3000_0021, 1'b0);
    fork
      txn(3, 1'b1, HANG_ADR, 32'hCAFE_0003, nn[3]);
      begin
        repeat (2) @(posedge clk);
        txn(1, 1'b0, 32'h3000_0020, 32'h0, nn[1]);
      end
    join
    chk("timeout latency", 32'(nn[3]), 32'd5);

    // Slave ack lands on the cycle the timeout would fire
    slave_lat = 3;
    gnt_q.push_back(0);
    expect_ack(0, 1'b0, 32'h5000_0000, 32'h0, 32'h5000_0001, 1'b0);
    txn(0, 1'b0, 32'h5000_0000, 32'h0, nn[0]);
    chk("race latency", 32'(nn[0]), 32'd5);
    slave_lat = 2;

    // Abort: m2 drops cyc without an ack
    gnt_q.push_back(2);
    @(posedge clk);
    #1;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[64 +: 32] = HANG_ADR;
    wait_grant(2);
    @(posedge clk);
    #1;
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    @(negedge clk);
    chk("abort s_cyc", 32'(s_cyc_o), 32'd0);
    chk("abort no ack", 32'(m_ack_o), 32'd0);
    @(negedge clk);
    chk("abort idle", 32'(grant_o), 32'd0);

    // Reset while m2 holds the bus, then m2/m3 request together
    gnt_q.push_back(2);
    @(posedge clk);
    #1;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[64 +: 32] = HANG_ADR;
    wait_grant(2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid reset grant", 32'(grant_o), 32'd0);
    chk("mid reset s_cyc", 32'(s_cyc_o), 32'd0);
    chk("mid reset s_stb", 32'(s_stb_o), 32'd0);
    chk("mid reset s_adr", s_adr_o, 32'd0);
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    gnt_q.push_back(2);
    gnt_q.push_back(3);
    expect_ack(2, 1'b0, 32'h6000_0200, 32'h0, 32'h6000_0201, 1'b0);
    expect_ack(3, 1'b0, 32'h6000_0300, 32'h0, 32'h6000_0301, 1'b0);
    fork
      txn(2, 1'b0, 32'h6000_0200, 32'h0, nn[2]);
      txn(3, 1'b0, 32'h6000_0300, 32'h0, nn[3]);
    join

    for (int i = 0; i < 30 && (exp_q.size() != 0 || gnt_q.size() != 0); i++) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size() + gnt_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
